// File: rtl/id_ctrl_pipe.sv
// id_ctrl_pipe: MIPS-style ID-stage control decode plus the ID/EX, EX/MEM and
// MEM/WB control-bundle registers, with load-use stall detection.
// Optional build macro ID_CTRL_JUMP_EN adds j / jal / jr decode; without it
// those encodings are illegal and the jump outputs stay at zero.
module id_ctrl_pipe #(
    parameter int ALU_CTRL_W = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [31:0]           instr,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic                  ex_branch_ne,
    output logic                  ex_alu_source,
    output logic                  ex_alu_source_shift,
    output logic                  ex_jump,
    output logic                  ex_jump_reg,
    output logic                  ex_link,
    output logic [ALU_CTRL_W-1:0] ex_alu_control,
    output logic [REG_ADDR_W-1:0] ex_dst,
    output logic                  mem_valid,
    output logic                  mem_reg_write,
    output logic                  mem_mem_to_reg,
    output logic                  mem_mem_write,
    output logic [REG_ADDR_W-1:0] mem_dst,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic [REG_ADDR_W-1:0] wb_dst,
    output logic                  illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_NOR = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8;
    localparam logic [3:0] ALU_SRL = 4'd9;
    localparam logic [3:0] ALU_SRA = 4'd10;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  branch;
        logic                  branch_ne;
        logic                  alu_source;
        logic                  alu_source_shift;
        logic                  jump;
        logic                  jump_reg;
        logic                  link;
        logic [ALU_CTRL_W-1:0] alu_control;
        logic [REG_ADDR_W-1:0] dst;
    } ex_bundle_t;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic [REG_ADDR_W-1:0] dst;
    } mem_bundle_t;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] dst;
    } wb_bundle_t;

    logic [5:0] opcode_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    logic [4:0] rd_s;
    logic [5:0] funct_s;
    logic       unused_shamt_s;

    assign opcode_s       = instr[31:26];
    assign rs_s           = instr[25:21];
    assign rt_s           = instr[20:16];
    assign rd_s           = instr[15:11];
    assign funct_s        = instr[5:0];
    assign unused_shamt_s = ^instr[10:6];

    ex_bundle_t  dec_s;
    logic        dec_illegal_s;
    logic        rs_used_s;
    logic        rt_used_s;
    logic [3:0]  alu4_s;
    logic [4:0]  dst_field_s;
    logic        wr_s;

    ex_bundle_t  ex_d,  ex_q;
    mem_bundle_t mem_d, mem_q;
    wb_bundle_t  wb_d,  wb_q;
    logic        illegal_d, illegal_q;
    logic        stall_s;
    logic        rs_hit_s;
    logic        rt_hit_s;

    // Decode the ID instruction into a control bundle and its register-read usage.
    always_comb begin
        dec_s         = '0;
        dec_illegal_s = 1'b0;
        rs_used_s     = 1'b1;
        rt_used_s     = 1'b0;
        alu4_s        = ALU_NOP;
        dst_field_s   = 5'd0;
        wr_s          = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                rt_used_s   = 1'b1;
                wr_s        = 1'b1;
                dst_field_s = rd_s;
                case (funct_s)
                    6'h20, 6'h21: alu4_s = ALU_ADD;
                    6'h22, 6'h23: alu4_s = ALU_SUB;
                    6'h24:        alu4_s = ALU_AND;
                    6'h25:        alu4_s = ALU_OR;
                    6'h26:        alu4_s = ALU_XOR;
                    6'h27:        alu4_s = ALU_NOR;
                    6'h2a:        alu4_s = ALU_SLT;
                    6'h04:        alu4_s = ALU_SLL;
                    6'h06:        alu4_s = ALU_SRL;
                    6'h07:        alu4_s = ALU_SRA;
                    6'h00: begin
                        alu4_s                 = ALU_SLL;
                        dec_s.alu_source_shift = 1'b1;
                        rs_used_s              = 1'b0;
                    end
                    6'h02: begin
                        alu4_s                 = ALU_SRL;
                        dec_s.alu_source_shift = 1'b1;
                        rs_used_s              = 1'b0;
                    end
                    6'h03: begin
                        alu4_s                 = ALU_SRA;
                        dec_s.alu_source_shift = 1'b1;
                        rs_used_s              = 1'b0;
                    end
`ifdef ID_CTRL_JUMP_EN
                    6'h08: begin
                        dec_s.jump_reg = 1'b1;
                        wr_s           = 1'b0;
                    end
`endif
                    default: dec_illegal_s = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
                wr_s             = 1'b1;
                dst_field_s      = rt_s;
                dec_s.alu_source = 1'b1;
                dec_s.mem_to_reg = (opcode_s == OP_LW);
                case (opcode_s)
                    OP_ANDI: alu4_s = ALU_AND;
                    OP_ORI:  alu4_s = ALU_OR;
                    OP_XORI: alu4_s = ALU_XOR;
                    default: alu4_s = ALU_ADD;
                endcase
            end
            OP_SW: begin
                rt_used_s        = 1'b1;
                alu4_s           = ALU_ADD;
                dec_s.alu_source = 1'b1;
                dec_s.mem_write  = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                rt_used_s       = 1'b1;
                alu4_s          = ALU_SUB;
                dec_s.branch    = 1'b1;
                dec_s.branch_ne = (opcode_s == OP_BNE);
            end
            OP_J, OP_JAL: begin
                rs_used_s = 1'b0;
`ifdef ID_CTRL_JUMP_EN
                dec_s.jump  = 1'b1;
                dec_s.link  = (opcode_s == OP_JAL);
                wr_s        = (opcode_s == OP_JAL);
                dst_field_s = (opcode_s == OP_JAL) ? 5'd31 : 5'd0;
`else
                dec_illegal_s = 1'b1;
`endif
            end
            default: dec_illegal_s = 1'b1;
        endcase
        // Writes to $0 are dropped; non-writing instructions carry dst = 0.
        dec_s.reg_write   = wr_s && (dst_field_s != 5'd0);
        dec_s.dst         = dec_s.reg_write ? REG_ADDR_W'(dst_field_s) : '0;
        dec_s.alu_control = ALU_CTRL_W'(alu4_s);
    end

    // Load-use hazard: the load in EX targets a register the ID instruction reads.
    always_comb begin
        rs_hit_s = rs_used_s && (REG_ADDR_W'(rs_s) == ex_q.dst);
        rt_hit_s = rt_used_s && (REG_ADDR_W'(rt_s) == ex_q.dst);
        stall_s  = !rst && in_valid && !flush && ex_q.valid && ex_q.mem_to_reg
                   && (ex_q.dst != '0) && (rs_hit_s || rt_hit_s);
    end

    // Next-state for all stage registers; flush, stall, idle and illegal all inject a bubble.
    always_comb begin
        if (in_valid && !flush && !stall_s && !dec_illegal_s) begin
            ex_d       = dec_s;
            ex_d.valid = 1'b1;
        end else begin
            ex_d = '0;
        end
        illegal_d = in_valid && !flush && !stall_s && dec_illegal_s;
        mem_d     = '{valid: ex_q.valid, reg_write: ex_q.reg_write,
                      mem_to_reg: ex_q.mem_to_reg, mem_write: ex_q.mem_write,
                      dst: ex_q.dst};
        wb_d      = '{valid: mem_q.valid, reg_write: mem_q.reg_write,
                      mem_to_reg: mem_q.mem_to_reg, dst: mem_q.dst};
    end

    // Stage registers; reset clears every bundle to a bubble immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            illegal_q <= illegal_d;
        end
    end

    assign stall               = stall_s;
    assign ex_valid            = ex_q.valid;
    assign ex_reg_write        = ex_q.reg_write;
    assign ex_mem_to_reg       = ex_q.mem_to_reg;
    assign ex_mem_write        = ex_q.mem_write;
    assign ex_branch           = ex_q.branch;
    assign ex_branch_ne        = ex_q.branch_ne;
    assign ex_alu_source       = ex_q.alu_source;
    assign ex_alu_source_shift = ex_q.alu_source_shift;
    assign ex_jump             = ex_q.jump;
    assign ex_jump_reg         = ex_q.jump_reg;
    assign ex_link             = ex_q.link;
    assign ex_alu_control      = ex_q.alu_control;
    assign ex_dst              = ex_q.dst;
    assign mem_valid           = mem_q.valid;
    assign mem_reg_write       = mem_q.reg_write;
    assign mem_mem_to_reg      = mem_q.mem_to_reg;
    assign mem_mem_write       = mem_q.mem_write;
    assign mem_dst             = mem_q.dst;
    assign wb_valid            = wb_q.valid;
    assign wb_reg_write        = wb_q.reg_write;
    assign wb_mem_to_reg       = wb_q.mem_to_reg;
    assign wb_dst              = wb_q.dst;
    assign illegal             = illegal_q;

endmodule
